// File: rtl/ioctl_loader_pkg.sv
// Shared constants for the ioctl download engine: index width, well-known
// download indices and the loader FSM state encoding.
package ioctl_loader_pkg;

   localparam int unsigned IDX_W = 8;

   localparam logic [IDX_W-1:0] IDX_ROM = 8'd1;
   localparam logic [IDX_W-1:0] IDX_CAS = 8'd2;

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [ST_W-1:0] ST_IGNORE  = 3'd1;
   localparam logic [ST_W-1:0] ST_LOAD    = 3'd2;
   localparam logic [ST_W-1:0] ST_WRITE   = 3'd3;
   localparam logic [ST_W-1:0] ST_FLUSH   = 3'd4;
   localparam logic [ST_W-1:0] ST_STRETCH = 3'd5;

endpackage

// File: rtl/ioctl_region_match.sv
// Priority encoder from a download index to the lowest matching region entry.
module ioctl_region_match
   import ioctl_loader_pkg::*;
#(
   parameter int unsigned NUM_REGIONS = 4,
   parameter int unsigned RW          = 2
) (
   input  logic [IDX_W-1:0]             ioctl_index,
   input  logic [NUM_REGIONS*IDX_W-1:0] map_index,
   output logic                         hit,
   output logic [RW-1:0]                region
);

   // Scan from the top so the lowest matching entry wins.
   always_comb begin
      hit    = 1'b0;
      region = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (map_index[i*IDX_W +: IDX_W] == ioctl_index) begin
            hit    = 1'b1;
            region = RW'(i);
         end
      end
   end

endmodule

// File: rtl/ioctl_sram_loader.sv
// ioctl byte stream to 16-bit SRAM download engine with per-index regions
// and a stretched core reset around held-region loads.
module ioctl_sram_loader
   import ioctl_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 21,
   parameter int unsigned BYTES       = 2,
   parameter int unsigned NUM_REGIONS = 4,
   parameter int unsigned WE_CYCLES   = 2,
   parameter int unsigned STRETCH     = 64,
   parameter logic [7:0]  PAD         = 8'hFF
) (
   input  logic                          clk_sys,
   input  logic                          reset,
   input  logic                          ioctl_download,
   input  logic [IDX_W-1:0]              ioctl_index,
   input  logic                          ioctl_wr,
   input  logic [7:0]                    ioctl_dout,
   input  logic [NUM_REGIONS*IDX_W-1:0]  map_index,
   input  logic [NUM_REGIONS*ADDR_W-1:0] map_base,
   input  logic [NUM_REGIONS-1:0]        map_hold,
   output logic [ADDR_W-1:0]             sram_a,
   output logic [8*BYTES-1:0]            sram_dout,
   output logic                          sram_we,
   output logic                          core_reset,
   output logic                          busy,
   output logic [ADDR_W-1:0]             words_written,
   output logic                          overflow
);

   localparam int unsigned LW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned TW = $clog2(WE_CYCLES + 1);
   localparam int unsigned SW = $clog2(STRETCH + 1);
   localparam int unsigned RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   logic [ST_W-1:0]          state, state_nx, end_st;
   logic [RW-1:0]            region, region_nx, match_region;
   logic [BYTES-1:0][7:0]    lane_q, lane_nx, pend_word, pend_nx;
   logic [LW-1:0]            lane_cnt, lane_cnt_nx;
   logic                     pend_vld, pend_vld_nx, ending, ending_nx;
   logic [TW-1:0]            tmr, tmr_nx;
   logic [SW-1:0]            scnt, scnt_nx;
   logic [ADDR_W-1:0]        a_nx, ww_nx, base;
   logic [8*BYTES-1:0]       dout_nx, flush_word;
   logic                     we_nx, ovf_nx, core_reset_nx;
   logic                     dl_q, rise, fall, match_hit, accept, word_done, wr_end;

   ioctl_region_match #(
      .NUM_REGIONS (NUM_REGIONS),
      .RW          (RW)
   ) u_match (
      .ioctl_index (ioctl_index),
      .map_index   (map_index),
      .hit         (match_hit),
      .region      (match_region)
   );

   assign rise = ioctl_download & ~dl_q;
   assign fall = ~ioctl_download & dl_q;

   // Next-state, lane packer, write timer and stretch counter.
   always_comb begin
      state_nx    = state;
      region_nx   = region;
      lane_nx     = lane_q;
      lane_cnt_nx = lane_cnt;
      pend_nx     = pend_word;
      pend_vld_nx = pend_vld;
      ending_nx   = ending;
      tmr_nx      = tmr;
      scnt_nx     = scnt;
      a_nx        = sram_a;
      dout_nx     = sram_dout;
      we_nx       = sram_we;
      ww_nx       = words_written;
      ovf_nx      = overflow;
      word_done   = 1'b0;
      wr_end      = 1'b0;
      flush_word  = '0;
      base        = map_base[ADDR_W*32'(region) +: ADDR_W];
      end_st      = map_hold[region] ? ST_STRETCH : ST_IDLE;
      // The byte on the falling-edge cycle still counts.
      accept      = ioctl_wr && (ioctl_download || dl_q) &&
                    (state == ST_LOAD || state == ST_WRITE);

      if (accept) begin
         lane_nx[lane_cnt] = ioctl_dout;
         if (lane_cnt == LW'(BYTES - 1)) begin
            word_done   = 1'b1;
            lane_cnt_nx = '0;
         end else begin
            lane_cnt_nx = lane_cnt + LW'(1);
         end
      end

      for (int k = 0; k < BYTES; k++) begin
         flush_word[8*k +: 8] = (LW'(k) < lane_cnt_nx) ? lane_nx[k] : PAD;
      end

      if (state == ST_WRITE || state == ST_FLUSH) begin
         if (tmr == TW'(WE_CYCLES)) begin
            wr_end = 1'b1;
            we_nx  = 1'b0;
            tmr_nx = '0;
            ww_nx  = words_written + ADDR_W'(1);
         end else begin
            we_nx  = 1'b1;
            tmr_nx = tmr + TW'(1);
         end
      end

      case (state)
         ST_IDLE, ST_STRETCH: begin
            if (rise) begin
               region_nx   = match_region;
               lane_cnt_nx = '0;
               pend_vld_nx = 1'b0;
               ending_nx   = 1'b0;
               scnt_nx     = '0;
               if (match_hit) begin
                  ww_nx    = '0;
                  state_nx = ST_LOAD;
               end else begin
                  state_nx = ST_IGNORE;
               end
            end else if (state == ST_STRETCH) begin
               if (scnt == SW'(STRETCH - 1)) state_nx = ST_IDLE;
               else                          scnt_nx  = scnt + SW'(1);
            end
         end
         ST_IGNORE: begin
            if (fall) state_nx = ST_IDLE;
         end
         ST_LOAD: begin
            if (word_done) begin
               dout_nx   = lane_nx;
               a_nx      = base + words_written;
               tmr_nx    = '0;
               ending_nx = fall;
               state_nx  = ST_WRITE;
            end else if (fall) begin
               if (lane_cnt_nx != '0) begin
                  dout_nx     = flush_word;
                  a_nx        = base + words_written;
                  lane_cnt_nx = '0;
                  tmr_nx      = '0;
                  state_nx    = ST_FLUSH;
               end else begin
                  scnt_nx  = '0;
                  state_nx = end_st;
               end
            end
         end
         ST_WRITE: begin
            if (fall) ending_nx = 1'b1;
            // A word completing mid-write parks in the pending slot, newest wins.
            if (word_done) begin
               ovf_nx      = 1'b1;
               pend_nx     = lane_nx;
               pend_vld_nx = 1'b1;
            end
            if (wr_end) begin
               if (pend_vld_nx) begin
                  dout_nx     = pend_nx;
                  a_nx        = base + words_written + ADDR_W'(1);
                  pend_vld_nx = 1'b0;
               end else if (ending_nx) begin
                  if (lane_cnt_nx != '0) begin
                     dout_nx     = flush_word;
                     a_nx        = base + words_written + ADDR_W'(1);
                     lane_cnt_nx = '0;
                     state_nx    = ST_FLUSH;
                  end else begin
                     scnt_nx  = '0;
                     state_nx = end_st;
                  end
               end else begin
                  state_nx = ST_LOAD;
               end
            end
         end
         ST_FLUSH: begin
            if (wr_end) begin
               scnt_nx  = '0;
               state_nx = end_st;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      core_reset_nx = ((state_nx == ST_LOAD || state_nx == ST_WRITE || state_nx == ST_FLUSH) &&
                       map_hold[region_nx]) || (state_nx == ST_STRETCH);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         region        <= '0;
         lane_q        <= '0;
         lane_cnt      <= '0;
         pend_word     <= '0;
         pend_vld      <= 1'b0;
         ending        <= 1'b0;
         tmr           <= '0;
         scnt          <= '0;
         dl_q          <= 1'b0;
         sram_a        <= '0;
         sram_dout     <= '0;
         sram_we       <= 1'b0;
         core_reset    <= 1'b0;
         busy          <= 1'b0;
         words_written <= '0;
         overflow      <= 1'b0;
      end else begin
         state         <= state_nx;
         region        <= region_nx;
         lane_q        <= lane_nx;
         lane_cnt      <= lane_cnt_nx;
         pend_word     <= pend_nx;
         pend_vld      <= pend_vld_nx;
         ending        <= ending_nx;
         tmr           <= tmr_nx;
         scnt          <= scnt_nx;
         dl_q          <= ioctl_download;
         sram_a        <= a_nx;
         sram_dout     <= dout_nx;
         sram_we       <= we_nx;
         core_reset    <= core_reset_nx;
         busy          <= (state_nx != ST_IDLE);
         words_written <= ww_nx;
         overflow      <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_ioctl_sram_loader.sv
// Randomised self-checking bench for ioctl_sram_loader against a
// download-level reference model (byte list -> expected SRAM word list).
module tb_ioctl_sram_loader;
   import ioctl_loader_pkg::*;

   localparam int unsigned ADDR_W = 21;
   localparam int unsigned NR     = 4;
   localparam int unsigned WE     = 4;
   localparam int unsigned STR    = 64;

   logic                  clk_sys = 1'b0;
   logic                  reset = 1'b1;
   logic                  ioctl_download = 1'b0;
   logic [7:0]            ioctl_index = '0;
   logic                  ioctl_wr = 1'b0;
   logic [7:0]            ioctl_dout = '0;
   logic [NR*8-1:0]       map_index;
   logic [NR*ADDR_W-1:0]  map_base;
   logic [NR-1:0]         map_hold;
   logic [ADDR_W-1:0]     sram_a, words_written;
   logic [15:0]           sram_dout;
   logic                  sram_we, core_reset, busy, overflow;

   logic [7:0]            idx_tab [NR];
   logic [ADDR_W-1:0]     base_tab[NR];
   logic                  hold_tab[NR];

   int                    n_checks = 0;
   int                    n_errors = 0;
   int                    cyc = 0;
   int                    first_we_cyc = -1;
   logic [36:0]           got_q[$];

   ioctl_sram_loader #(
      .ADDR_W      (ADDR_W),
      .BYTES       (2),
      .NUM_REGIONS (NR),
      .WE_CYCLES   (WE),
      .STRETCH     (STR),
      .PAD         (8'hFF)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_dout     (ioctl_dout),
      .map_index      (map_index),
      .map_base       (map_base),
      .map_hold       (map_hold),
      .sram_a         (sram_a),
      .sram_dout      (sram_dout),
      .sram_we        (sram_we),
      .core_reset     (core_reset),
      .busy           (busy),
      .words_written  (words_written),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // SRAM bus monitor: capture each write, check data setup and strobe width.
   logic        we_prev = 1'b0;
   logic [36:0] ad_prev = '0;
   int          hi_cnt = 0;
   always @(negedge clk_sys) begin
      if (reset) begin
         we_prev = 1'b0;
         hi_cnt  = 0;
      end else begin
         if (sram_we && !we_prev) begin
            check("dout_setup", {sram_a, sram_dout}, ad_prev);
            got_q.push_back({sram_a, sram_dout});
            if (first_we_cyc < 0) first_we_cyc = cyc;
         end
         if (sram_we) hi_cnt++;
         else if (we_prev) begin
            check("we_width", hi_cnt, WE);
            hi_cnt = 0;
         end
         we_prev = sram_we;
         ad_prev = {sram_a, sram_dout};
      end
   end

   task automatic wait_idle(output int cr, output bit done);
      cr   = 0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (!busy) done = 1'b1;
         else begin
            if (core_reset) cr++;
            tick();
         end
      end
   endtask

   task automatic run_download(input logic [7:0] idx, input logic [7:0] b[$],
                               input bit together, input int gap);
      bit          hit = 1'b0;
      bit          hold = 1'b0;
      bit          done, post;
      logic [ADDR_W-1:0] base = '0;
      logic [7:0]  lo, hi;
      logic [36:0] exp_q[$];
      int          n, nw, cr, wr_cyc;
      for (int i = 0; i < NR; i++) begin
         if (!hit && idx_tab[i] == idx) begin
            hit  = 1'b1;
            base = base_tab[i];
            hold = hold_tab[i];
         end
      end
      n  = b.size();
      nw = hit ? (n + 1) / 2 : 0;
      for (int w = 0; w < nw; w++) begin
         lo = b[2*w];
         hi = (2*w + 1 < n) ? b[2*w+1] : 8'hFF;
         exp_q.push_back({ADDR_W'(base + ADDR_W'(w)), hi, lo});
      end
      post   = hit && (together || (n % 2 == 1));
      wr_cyc = 0;

      got_q.delete();
      first_we_cyc = -1;
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
      tick();
      check("busy_start", busy, 1'b1);
      check("creset_load", core_reset, hit && hold);
      for (int k = 0; k < n; k++) begin
         ioctl_dout = b[k];
         ioctl_wr   = 1'b1;
         if (k == n - 1 && together) ioctl_download = 1'b0;
         if (k == 1) wr_cyc = cyc;
         tick();
         ioctl_wr = 1'b0;
         if (!(k == n - 1 && together)) repeat (gap) tick();
      end
      if (!together) begin
         ioctl_download = 1'b0;
         tick();
      end
      if (!hit) check("busy_ignore_end", busy, 1'b0);
      wait_idle(cr, done);
      check("end_timeout", done, 1'b1);
      check("creset_cycles", cr, (hit && hold) ? STR + (post ? WE + 1 : 0) : 0);
      check("num_writes", got_q.size(), nw);
      for (int i = 0; i < nw && i < got_q.size(); i++) check("write", got_q[i], exp_q[i]);
      if (hit) check("words_written", words_written, nw);
      check("overflow_clear", overflow, 1'b0);
      if (hit && n >= 2) check("first_latency", first_we_cyc - wr_cyc, 2);
      repeat (3) tick();
   endtask

   task automatic run_overflow();
      logic [7:0] b[6];
      int         cr;
      bit         done;
      for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
      got_q.delete();
      ioctl_index    = IDX_ROM;
      ioctl_download = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         ioctl_dout = b[k];
         ioctl_wr   = 1'b1;
         tick();
      end
      ioctl_wr = 1'b0;
      repeat (20) tick();
      check("ovf_flag", overflow, 1'b1);
      ioctl_download = 1'b0;
      tick();
      wait_idle(cr, done);
      check("ovf_timeout", done, 1'b1);
      check("ovf_writes", got_q.size(), 2);
      check("ovf_w0", got_q[0], {21'h001000, b[1], b[0]});
      check("ovf_w1", got_q[1], {21'h001001, b[5], b[4]});
      check("ovf_ww", words_written, 2);
      repeat (3) tick();
   endtask

   initial begin
      logic [7:0] bq[$];
      logic [7:0] pool[5];
      int         n;
      bit         seen;

      idx_tab[0] = IDX_ROM; base_tab[0] = 21'h001000; hold_tab[0] = 1'b1;
      idx_tab[1] = IDX_CAS; base_tab[1] = 21'h00ABCD; hold_tab[1] = 1'b0;
      idx_tab[2] = 8'd5;    base_tab[2] = 21'h1FFFFF; hold_tab[2] = 1'b1;
      idx_tab[3] = IDX_ROM; base_tab[3] = 21'h005555; hold_tab[3] = 1'b0;
      for (int i = 0; i < NR; i++) begin
         map_index[i*8 +: 8]          = idx_tab[i];
         map_base[i*ADDR_W +: ADDR_W] = base_tab[i];
         map_hold[i]                  = hold_tab[i];
      end
      pool = '{IDX_ROM, IDX_CAS, 8'd5, 8'd7, 8'd9};

      repeat (3) tick();
      check("rst_a", sram_a, 0);
      check("rst_dout", sram_dout, 0);
      check("rst_we", sram_we, 0);
      check("rst_creset", core_reset, 0);
      check("rst_busy", busy, 0);
      check("rst_ww", words_written, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      repeat (2) tick();

      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_download(IDX_ROM, bq, 1'b0, 6);
      check("t1_w0", got_q[0], {21'h001000, 16'h2211});
      check("t1_w1", got_q[1], {21'h001001, 16'h4433});

      bq = '{8'hAA, 8'hBB, 8'hCC};
      run_download(IDX_ROM, bq, 1'b0, 6);
      check("t2_w1", got_q[1], {21'h001001, 16'hFFCC});

      bq = '{8'h01, 8'h02, 8'h03};
      run_download(8'd7, bq, 1'b0, 6);

      bq = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
      run_download(8'd5, bq, 1'b0, 6);
      check("wrap_addr", got_q[1][36:16], 0);

      for (int t = 0; t < 25; t++) begin
         bq.delete();
         n = $urandom_range(1, 9);
         for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
         run_download(pool[$urandom_range(0, 4)], bq, 1'($urandom_range(0, 1)),
                      $urandom_range(6, 10));
      end

      run_overflow();

      // Reset in the middle of a write strobe.
      ioctl_index    = IDX_ROM;
      ioctl_download = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 2; k++) begin
         ioctl_dout = 8'(k + 8'h70);
         ioctl_wr   = 1'b1;
         tick();
      end
      ioctl_wr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (sram_we) seen = 1'b1;
         else tick();
      end
      check("midwr_we_seen", seen, 1'b1);
      #1;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      #1;
      check("midrst_we", sram_we, 0);
      check("midrst_a", sram_a, 0);
      check("midrst_dout", sram_dout, 0);
      check("midrst_creset", core_reset, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ww", words_written, 0);
      check("midrst_ovf", overflow, 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      bq = '{8'hDE, 8'hAD, 8'hBE};
      run_download(IDX_ROM, bq, 1'b1, 7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
